fifo_word_packer: RTL and testbench

- Sits directly downstream of the decap synchronous FIFO.
- Pops IW-bit items from the FIFO and packs them LSB-first into a continuous bit stream.
- Emits the stream as OW-bit words over a valid/ready handshake to the memory-write stage.
- Each frame is started by start_i with an item count. The last word is zero-padded, and done_o pulses when the frame finishes.

---
 rtl/word_packer_pkg.sv | 29 ++
 rtl/pack_accum.sv | 76 +++++++
 rtl/fifo_word_packer.sv | 169 ++++++++++++++++
 tb/tb_fifo_word_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_packer_pkg.sv
// Shared constants for the FIFO word packer: default widths, FSM encoding, accumulator sizing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package word_packer_pkg;

  localparam int IW_DEF = 24;  // item width, matches 2x12-bit FIFO word
  localparam int OW_DEF = 64;  // output word width
  localparam int CW_DEF = 12;  // item count width

  // FSM encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_FLUSH_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_RUN   = ST_RUN_ENC,
    S_FLUSH = ST_FLUSH_ENC,
    S_DONE  = ST_DONE_ENC
  } state_t;

  // One full output word plus room for the item being captured and the one
  // already requested from the FIFO.
  function automatic int accw(input int iw, input int ow);
    return ow + 2 * iw;
  endfunction

endpackage

// File: rtl/pack_accum.sv
// Bit accumulator: inserts IW-bit items at offset fill, extracts OW-bit words LSB-first.
// Latency: captured item is visible for extraction the cycle after capture.
// Backpressure: extraction only happens when out_free is high; otherwise data is held.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   cap, din      capture din at bit offset fill this cycle
//   out_free      downstream output register can take a word this cycle
//   flush         frame tail: emit a short (zero-padded) final word if 0<fill<OW
//   fill          number of valid bits held
//   ext_vld/dat   a word is extracted this cycle; ext_dat is the word
module pack_accum
  import word_packer_pkg::*;
#(
  parameter  int IW   = IW_DEF,
  parameter  int OW   = OW_DEF,
  localparam int ACCW = accw(IW, OW),
  localparam int FW   = $clog2(ACCW + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap,
  input  logic [IW-1:0] din,
  input  logic          out_free,
  input  logic          flush,
  output logic [FW-1:0] fill,
  output logic          ext_vld,
  output logic [OW-1:0] ext_dat
);

  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_ins;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_add;
  logic            ext_full;
  logic            ext_tail;

  // Bits at and above fill are always zero (insert ORs into the empty region,
  // shifts are logical), so OR-insertion is safe and the tail word is already
  // zero-padded without masking.
  always_comb begin
    acc_ins = acc_q;
    if (cap) begin
      acc_ins = acc_q | (ACCW'(din) << fill_q);
    end
  end

  assign fill_add = cap ? FW'(IW) : '0;

  // A full word never depends on the item captured this cycle (it lands at
  // offset >= OW), so capture and extraction can share a cycle.
  assign ext_full = (fill_q >= FW'(OW)) && out_free;
  // During flush no item is in flight, so acc_q is the complete remainder.
  assign ext_tail = flush && (fill_q != '0) && (fill_q < FW'(OW)) && out_free;

  assign ext_vld = ext_full || ext_tail;
  assign ext_dat = acc_q[OW-1:0];
  assign fill    = fill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else if (ext_full) begin
      acc_q  <= acc_ins >> OW;
      fill_q <= fill_q + fill_add - FW'(OW);
    end else if (ext_tail) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_ins;
      fill_q <= fill_q + fill_add;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs IW-bit FIFO items LSB-first into OW-bit words; last word zero-padded, done_o per frame.
// Latency: FIFO data 1 cycle after rd_o; first word registered on word_o 1 cycle after a word's bits are held.
// Backpressure: word_o/valid_o held until ready_i; popping stops when the accumulator has no room.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i, count_i   frame start (sampled in IDLE only) and item count
//   empty_i, rd_o      FIFO empty flag and pop request
//   din_i              FIFO read data, valid the cycle after rd_o
//   word_o, valid_o    packed output word and its valid, accepted with ready_i
//   busy_o, done_o     not-IDLE indicator and one-cycle end-of-frame pulse
//   last_o             final word of frame marker (only with WORD_PACKER_LAST_EN)
// Optional feature macro: WORD_PACKER_LAST_EN adds last_o.
module fifo_word_packer
  import word_packer_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] count_i,
  input  logic          empty_i,
  output logic          rd_o,
  input  logic [IW-1:0] din_i,
  output logic [OW-1:0] word_o,
  output logic          valid_o,
`ifdef WORD_PACKER_LAST_EN
  output logic          last_o,
`endif
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int ACCW = accw(IW, OW);
  localparam int FW   = $clog2(ACCW + 1);
  localparam logic [FW:0] IW_W   = (FW+1)'(IW);
  localparam logic [FW:0] ACCW_W = (FW+1)'(ACCW);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] received_q;
  logic          rd_pend_q;
  logic [FW-1:0] fill;
  logic          ext_vld;
  logic [OW-1:0] ext_dat;
  logic          out_free;
  logic [FW:0]   need;

  assign out_free = !valid_o || ready_i;

  // Room check counts the item already in flight so the accumulator never
  // overflows regardless of whether a word leaves this cycle.
  assign need = {1'b0, fill} + IW_W + (rd_pend_q ? IW_W : '0);
  assign rd_o = (state_q == S_RUN) && (issued_q < count_q) && !empty_i && (need <= ACCW_W);

  pack_accum #(
    .IW(IW),
    .OW(OW)
  ) u_accum (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cap      (rd_pend_q),
    .din      (din_i),
    .out_free (out_free),
    .flush    (state_q == S_FLUSH),
    .fill     (fill),
    .ext_vld  (ext_vld),
    .ext_dat  (ext_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (count_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (received_q == count_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Leave as soon as the last word is being accepted so done_o lands
        // on the cycle right after the final handshake.
        if ((fill == '0) && out_free) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_o;
      if ((state_q == S_IDLE) && start_i) begin
        count_q    <= count_i;
        issued_q   <= '0;
        received_q <= '0;
      end else begin
        if (rd_o) begin
          issued_q <= issued_q + CW'(1);
        end
        if (rd_pend_q) begin
          received_q <= received_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_o  <= '0;
      valid_o <= 1'b0;
    end else if (ext_vld) begin
      word_o  <= ext_dat;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef WORD_PACKER_LAST_EN
  // Once every item has landed nothing more is in flight, so a word that
  // drains the accumulator to zero is the frame's last.
  logic final_word;
  assign final_word = (received_q == count_q) && (fill <= FW'(OW));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_o <= 1'b0;
    end else if (ext_vld) begin
      last_o <= final_word;
    end else if (ready_i) begin
      last_o <= 1'b0;
    end
  end
`endif

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

  localparam int IW = 24;
  localparam int OW = 64;
  localparam int CW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [CW-1:0] count_i;
  logic          empty_i;
  logic          rd_o;
  logic [IW-1:0] din_i;
  logic [OW-1:0] word_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          done_o;
`ifdef WORD_PACKER_LAST_EN
  logic          last_o;
`endif

  fifo_word_packer #(.IW(IW), .OW(OW), .CW(CW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .count_i (count_i),
    .empty_i (empty_i),
    .rd_o    (rd_o),
    .din_i   (din_i),
    .word_o  (word_o),
    .valid_o (valid_o),
`ifdef WORD_PACKER_LAST_EN
    .last_o  (last_o),
`endif
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] fifo_q[$];
  logic [IW-1:0] frame_items[$];
  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];

  int cyc = 0, pops = 0, overreads = 0, unstable = 0;
  int done_cnt = 0, done_cyc = -1, acc_cyc = -1, start_cyc = -1;
  int last_cnt = 0, last_idx = -1;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  int gap_mode = 0;  // 0: no gaps, 1: toggle every 3 cycles, 2: random

  // FIFO model and output monitor: samples at negedge, drives at posedge+1.
  initial begin
    logic          rd_s, hold, gap;
    logic [OW-1:0] hold_word;
    logic [IW-1:0] item;
    hold = 1'b0; hold_word = '0; item = '0;
    din_i = '0; empty_i = 1'b1; ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (hold && (!valid_o || word_o !== hold_word)) unstable++;
      hold      = valid_o && !ready_i;
      hold_word = word_o;
      rd_s = 1'b0;
      if (rd_o === 1'b1) begin
        if (empty_i || fifo_q.size() == 0) overreads++;
        else begin
          item = fifo_q.pop_front();
          pops++;
          rd_s = 1'b1;
        end
      end
      if (valid_o === 1'b1 && ready_i) begin
        got_q.push_back(word_o);
        acc_cyc = cyc;
`ifdef WORD_PACKER_LAST_EN
        if (last_o) begin last_cnt++; last_idx = got_q.size(); end
`endif
      end
      if (done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (start_i && busy_o === 1'b0) start_cyc = cyc;
      @(posedge clk_i);
      #1;
      if (rd_s) din_i = item;
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom_range(0, 1));
        default: ready_i = 1'b0;
      endcase
      case (gap_mode)
        0:       gap = 1'b0;
        1:       gap = ((cyc / 3) % 2) == 1;
        default: gap = ($urandom_range(0, 3) == 0);
      endcase
      empty_i = (fifo_q.size() == 0) || gap;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the frame is one long bit string (item k occupies bits
  // k*IW .. k*IW+IW-1), cut into OW-bit words, zero beyond the end.
  task automatic build_exp();
    int nbits, nw;
    logic [OW-1:0] w;
    logic [IW-1:0] it;
    exp_q.delete();
    nbits = frame_items.size() * IW;
    nw    = (nbits + OW - 1) / OW;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < OW; b++) begin
        int idx;
        idx = i * OW + b;
        if (idx < nbits) begin
          it   = frame_items[idx / IW];
          w[b] = it[idx % IW];
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic run_frame(input string name, input bit bp, input bit poke);
    int  n;
    bit  seen_v;
    n = frame_items.size();
    build_exp();
    foreach (frame_items[i]) fifo_q.push_back(frame_items[i]);
    got_q.delete();
    pops = 0; overreads = 0; unstable = 0; done_cnt = 0;
    done_cyc = -1; acc_cyc = -1; start_cyc = -1; last_cnt = 0; last_idx = -1;
    seen_v = 1'b0;
    step(1);
    start_i = 1'b1; count_i = CW'(n);
    step(1);
    start_i = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt > 0) break;
      if (poke && k == 3) begin
        start_i = 1'b1; count_i = CW'(5);
        step(1);
        start_i = 1'b0;
        continue;
      end
      if (bp && !seen_v && valid_o) begin
        seen_v = 1'b1;
        step(20);
        chk({name, "_bp_rd_stalled"}, 64'(rd_o), 64'd0);
        chk({name, "_bp_valid_held"}, 64'(valid_o), 64'd1);
        chk({name, "_bp_pops_partial"}, 64'(pops < n), 64'd1);
        rdy_mode = 0;
      end
      step(1);
    end
    chk({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    step(3);
    chk({name, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", name, i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    chk({name, "_pops"}, 64'(pops), 64'(n));
    chk({name, "_overreads"}, 64'(overreads), 64'd0);
    chk({name, "_stable"}, 64'(unstable), 64'd0);
    chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
    if (n == 0) chk({name, "_done_timing"}, 64'(done_cyc), 64'(start_cyc + 1));
    else        chk({name, "_done_timing"}, 64'(done_cyc), 64'(acc_cyc + 1));
`ifdef WORD_PACKER_LAST_EN
    chk({name, "_last_cnt"}, 64'(last_cnt), (n == 0) ? 64'd0 : 64'd1);
    if (n != 0) chk({name, "_last_pos"}, 64'(last_idx), 64'(exp_q.size()));
`endif
  endtask

  initial begin
    int dc;
    rst_i = 1'b1; start_i = 1'b0; count_i = '0;
    step(2);
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_word", word_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;
    step(1);

    // Exact fit: 8 x 24 = 192 bits = 3 words.
    frame_items.delete();
    for (int i = 1; i <= 8; i++) frame_items.push_back(IW'(i));
    run_frame("exact", 1'b0, 1'b0);

    // Partial tail: 72 bits -> 2 words, second one carries 8 bits.
    frame_items.delete();
    frame_items.push_back(24'hAAAAAA);
    frame_items.push_back(24'hBBBBBB);
    frame_items.push_back(24'hCCCCCC);
    run_frame("tail", 1'b0, 1'b0);
    chk("tail_word0_lit", (got_q.size() > 0) ? got_q[0] : 'x, 64'hCCCCBBBBBBAAAAAA);
    chk("tail_word1_lit", (got_q.size() > 1) ? got_q[1] : 'x, 64'h00000000000000CC);

    // Back-pressure: ready low until 20 cycles after the first valid.
    frame_items.delete();
    for (int i = 0; i < 16; i++) frame_items.push_back(IW'($urandom()));
    rdy_mode = 2;
    run_frame("bp", 1'b1, 1'b0);
    rdy_mode = 0;

    // FIFO gaps plus an ignored start pulse while busy.
    frame_items.delete();
    for (int i = 0; i < 10; i++) frame_items.push_back(IW'($urandom()));
    gap_mode = 1;
    run_frame("gaps", 1'b0, 1'b1);
    gap_mode = 0;

    // Empty frame.
    frame_items.delete();
    run_frame("zero", 1'b0, 1'b0);

    // Reset mid-run after two words.
    frame_items.delete();
    for (int i = 0; i < 16; i++) frame_items.push_back(IW'($urandom()));
    foreach (frame_items[i]) fifo_q.push_back(frame_items[i]);
    got_q.delete(); done_cnt = 0;
    step(1);
    start_i = 1'b1; count_i = CW'(16);
    step(1);
    start_i = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (got_q.size() >= 2) break;
      step(1);
    end
    chk("rst_mid_two_words", 64'(got_q.size() >= 2), 64'd1);
    rst_i = 1'b1;
    step(1);
    chk("rst_mid_rd", 64'(rd_o), 64'd0);
    chk("rst_mid_valid", 64'(valid_o), 64'd0);
    chk("rst_mid_word", word_o, 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;
    dc = done_cnt;
    step(6);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(dc));
    fifo_q.delete();
    step(1);
    frame_items.delete();
    for (int i = 0; i < 3; i++) frame_items.push_back(IW'($urandom()));
    run_frame("after_rst", 1'b0, 1'b0);

    // Randomized frames with random ready and FIFO gaps.
    rdy_mode = 1; gap_mode = 2;
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 40);
      frame_items.delete();
      for (int i = 0; i < n; i++) frame_items.push_back(IW'($urandom()));
      run_frame($sformatf("rand%0d", f), 1'b0, 1'b0);
    end
    rdy_mode = 0; gap_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
